key_cfg_ctrl: RTL and testbench

- Consumes the one-cycle debounced key pulses `key_vld` from the key debounce stage.
- Turns them into the edge-detection pipeline's run-time configuration: display mode and binarisation/Sobel threshold.
- Key edits go into shadow registers. Shadow values are committed to the outputs only on a rising edge of `vsync`, so no frame is processed with mixed settings.

---
 rtl/edge_cfg_pkg.sv | 43 ++++
 rtl/key_cfg_ctrl_if.sv | 22 ++
 rtl/key_cfg_ctrl_sat_step.sv | 41 ++++
 rtl/key_cfg_ctrl.sv | 136 +++++++++++++
 tb/tb_key_cfg_ctrl.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/edge_cfg_pkg.sv
// Shared configuration constants for the edge-detection pipeline:
// display mode encodings, key bit positions and threshold defaults.
package edge_cfg_pkg;

    // Display modes, in key-cycling order
    localparam logic [1:0] MODE_RAW   = 2'd0;
    localparam logic [1:0] MODE_GRAY  = 2'd1;
    localparam logic [1:0] MODE_SOBEL = 2'd2;
    localparam logic [1:0] MODE_BIN   = 2'd3;

    // Bit positions inside key_vld
    localparam int KEY_UP   = 0;
    localparam int KEY_DOWN = 1;
    localparam int KEY_MODE = 2;
    localparam int KEY_RST  = 3;

    // Threshold defaults, also used by the Sobel/binarise stages
    localparam int KEY_W_DEF    = 4;
    localparam int THR_W_DEF    = 8;
    localparam int THR_DEF_C    = 100;
    localparam int THR_STEP_C   = 5;
    localparam int THR_MIN_C    = 10;
    localparam int THR_MAX_C    = 250;

    // Next mode when the mode key is pressed: RAW -> GRAY -> SOBEL -> BIN -> RAW
    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        logic [1:0] nxt;
        case (mode)
            MODE_RAW:   nxt = MODE_GRAY;
            MODE_GRAY:  nxt = MODE_SOBEL;
            MODE_SOBEL: nxt = MODE_BIN;
            MODE_BIN:   nxt = MODE_RAW;
            default:    nxt = MODE_RAW;
        endcase
        return nxt;
    endfunction

    // Threshold keys only matter in modes that actually use a threshold
    function automatic logic thr_mode_active(input logic [1:0] mode);
        return (mode == MODE_SOBEL) || (mode == MODE_BIN);
    endfunction

endpackage

// File: rtl/key_cfg_ctrl_if.sv
// Key/frame-sync inputs and committed configuration outputs of key_cfg_ctrl.
interface key_cfg_ctrl_if #(
    parameter int KEY_W = 4,
    parameter int THR_W = 8
) ();
    logic [KEY_W-1:0] key_vld;
    logic             vsync;
    logic [THR_W-1:0] thr_cfg;
    logic [1:0]       mode_cfg;
    logic             cfg_upd;
    logic             pend;

    modport master (
        output key_vld, vsync,
        input  thr_cfg, mode_cfg, cfg_upd, pend
    );

    modport slave (
        input  key_vld, vsync,
        output thr_cfg, mode_cfg, cfg_upd, pend
    );
endinterface

// File: rtl/key_cfg_ctrl_sat_step.sv
// Saturating +/- THR_STEP on the threshold, clamped to [THR_MIN, THR_MAX],
// with a flag telling whether each result differs from the input.
module sat_step #(
    parameter int THR_W    = 8,
    parameter int THR_STEP = 5,
    parameter int THR_MIN  = 10,
    parameter int THR_MAX  = 250
) (
    input  logic [THR_W-1:0] thr_i,
    output logic [THR_W-1:0] up_o,
    output logic             up_chg_o,
    output logic [THR_W-1:0] dn_o,
    output logic             dn_chg_o
);
    // One extra bit so thr + STEP cannot wrap before the clamp
    localparam logic [THR_W:0] STEP_X  = (THR_W+1)'(THR_STEP);
    localparam logic [THR_W:0] MIN_X   = (THR_W+1)'(THR_MIN);
    localparam logic [THR_W:0] MAX_X   = (THR_W+1)'(THR_MAX);
    localparam logic [THR_W:0] FLOOR_X = MIN_X + STEP_X;

    logic [THR_W:0] sum_s;
    logic [THR_W:0] diff_s;

    // Clamped increment and decrement candidates
    always_comb begin
        sum_s  = {1'b0, thr_i} + STEP_X;
        diff_s = {1'b0, thr_i} - STEP_X;
        if (sum_s > MAX_X) begin
            up_o = MAX_X[THR_W-1:0];
        end else begin
            up_o = sum_s[THR_W-1:0];
        end
        if ({1'b0, thr_i} < FLOOR_X) begin
            dn_o = MIN_X[THR_W-1:0];
        end else begin
            dn_o = diff_s[THR_W-1:0];
        end
        up_chg_o = (up_o != thr_i);
        dn_chg_o = (dn_o != thr_i);
    end
endmodule

// File: rtl/key_cfg_ctrl.sv
// Key-driven run-time configuration for the edge pipeline. Key edits land in
// shadow registers; the shadow is copied to the outputs only on a vsync rise,
// so a frame never sees a half-applied configuration.
module key_cfg_ctrl
    import edge_cfg_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int THR_W    = THR_W_DEF,
    parameter int THR_DEF  = THR_DEF_C,
    parameter int THR_STEP = THR_STEP_C,
    parameter int THR_MIN  = THR_MIN_C,
    parameter int THR_MAX  = THR_MAX_C
) (
    input  logic           clk,
    input  logic           rst_n,
    key_cfg_ctrl_if.slave  bus
);
    if ((KEY_W < 4) || (THR_STEP <= 0) || (THR_MIN > THR_DEF) ||
        (THR_DEF > THR_MAX) || (THR_MAX >= (1 << THR_W))) begin : g_param_err
        $error("key_cfg_ctrl: illegal parameter set");
    end

    localparam logic [THR_W-1:0] THR_DEF_V = THR_W'(THR_DEF);

    logic [THR_W-1:0] thr_sh_q,  thr_sh_d;
    logic [1:0]       mode_sh_q, mode_sh_d;
    logic [THR_W-1:0] thr_cfg_q, thr_cfg_d;
    logic [1:0]       mode_cfg_q, mode_cfg_d;
    logic             cfg_upd_q, cfg_upd_d;
    logic             pend_q,    pend_d;
    logic             vsync_q;
    logic             vs_rise_q;
    logic             vs_rise_s;
    logic             act_s;
    logic             commit_s;

    logic [THR_W-1:0] up_val_s, dn_val_s;
    logic             up_chg_s, dn_chg_s;

    sat_step #(
        .THR_W    (THR_W),
        .THR_STEP (THR_STEP),
        .THR_MIN  (THR_MIN),
        .THR_MAX  (THR_MAX)
    ) u_sat_step (
        .thr_i    (thr_sh_q),
        .up_o     (up_val_s),
        .up_chg_o (up_chg_s),
        .dn_o     (dn_val_s),
        .dn_chg_o (dn_chg_s)
    );

    assign vs_rise_s = bus.vsync & ~vsync_q;
    assign commit_s  = vs_rise_q & pend_q;

    // Single prioritised key action into the shadow, plus pend/commit next state
    always_comb begin
        thr_sh_d   = thr_sh_q;
        mode_sh_d  = mode_sh_q;
        act_s      = 1'b0;
        if (bus.key_vld[KEY_RST]) begin
            if (thr_sh_q != THR_DEF_V) begin
                thr_sh_d = THR_DEF_V;
                act_s    = 1'b1;
            end else begin
                act_s    = 1'b0;
            end
        end else if (bus.key_vld[KEY_MODE]) begin
            mode_sh_d = next_mode(mode_sh_q);
            act_s     = 1'b1;
        end else if (bus.key_vld[KEY_UP]) begin
            if (thr_mode_active(mode_sh_q) && up_chg_s) begin
                thr_sh_d = up_val_s;
                act_s    = 1'b1;
            end else begin
                act_s    = 1'b0;
            end
        end else if (bus.key_vld[KEY_DOWN]) begin
            if (thr_mode_active(mode_sh_q) && dn_chg_s) begin
                thr_sh_d = dn_val_s;
                act_s    = 1'b1;
            end else begin
                act_s    = 1'b0;
            end
        end else begin
            act_s = 1'b0;
        end

        if (act_s) begin
            pend_d = 1'b1;
        end else if (commit_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        // Commit publishes the pre-action shadow; a same-cycle key edit waits
        if (commit_s) begin
            thr_cfg_d  = thr_sh_q;
            mode_cfg_d = mode_sh_q;
        end else begin
            thr_cfg_d  = thr_cfg_q;
            mode_cfg_d = mode_cfg_q;
        end
        cfg_upd_d = commit_s;
    end

    // State registers; vsync_q resets high so vsync already high gives no edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_sh_q   <= THR_DEF_V;
            mode_sh_q  <= MODE_RAW;
            thr_cfg_q  <= THR_DEF_V;
            mode_cfg_q <= MODE_RAW;
            cfg_upd_q  <= 1'b0;
            pend_q     <= 1'b0;
            vsync_q    <= 1'b1;
            vs_rise_q  <= 1'b0;
        end else begin
            thr_sh_q   <= thr_sh_d;
            mode_sh_q  <= mode_sh_d;
            thr_cfg_q  <= thr_cfg_d;
            mode_cfg_q <= mode_cfg_d;
            cfg_upd_q  <= cfg_upd_d;
            pend_q     <= pend_d;
            vsync_q    <= bus.vsync;
            vs_rise_q  <= vs_rise_s;
        end
    end

    assign bus.thr_cfg  = thr_cfg_q;
    assign bus.mode_cfg = mode_cfg_q;
    assign bus.cfg_upd  = cfg_upd_q;
    assign bus.pend     = pend_q;

endmodule

// File: tb/tb_key_cfg_ctrl.sv
// Directed bench for key_cfg_ctrl: a vector table for the main flow plus
// hand-written sequences for saturation, same-cycle commit and mid-run reset.
module tb_key_cfg_ctrl;

    logic clk;
    logic rst_n;

    key_cfg_ctrl_if #(.KEY_W(4), .THR_W(8)) bus ();

    key_cfg_ctrl #(
        .KEY_W(4), .THR_W(8), .THR_DEF(100), .THR_STEP(5), .THR_MIN(10), .THR_MAX(250)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] key;
        logic       vs;
        logic [7:0] thr;
        logic [1:0] mode;
        logic       upd;
        logic       pend;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic [3:0] key, input logic vs, input logic [7:0] thr,
                       input logic [1:0] mode, input logic upd, input logic pend);
        vec_t v;
        v.key = key; v.vs = vs; v.thr = thr; v.mode = mode; v.upd = upd; v.pend = pend;
        vecs.push_back(v);
    endtask

    // Drive inputs at a falling edge, let one rising edge consume them
    task automatic step(input logic [3:0] key, input logic vs);
        bus.key_vld = key;
        bus.vsync   = vs;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] thr, input logic [1:0] mode,
                       input logic upd, input logic pend);
        checks++;
        if (bus.thr_cfg !== thr || bus.mode_cfg !== mode || bus.cfg_upd !== upd || bus.pend !== pend) begin
            errors++;
            $display("FAIL %s: got thr=%0d mode=%0d upd=%0b pend=%0b, want thr=%0d mode=%0d upd=%0b pend=%0b",
                     name, bus.thr_cfg, bus.mode_cfg, bus.cfg_upd, bus.pend, thr, mode, upd, pend);
        end
    endtask

    initial begin
        // Mode cycling: one commit per vsync rise, threshold untouched
        add(4'h0,1,100,0,0,0); add(4'h0,0,100,0,0,0);
        add(4'h4,0,100,0,0,1); add(4'h0,1,100,0,0,1); add(4'h0,1,100,1,1,0); add(4'h0,0,100,1,0,0);
        add(4'h4,0,100,1,0,1); add(4'h0,1,100,1,0,1); add(4'h0,0,100,2,1,0);
        add(4'h4,0,100,2,0,1); add(4'h0,1,100,2,0,1); add(4'h0,0,100,3,1,0);
        add(4'h4,0,100,3,0,1); add(4'h0,1,100,3,0,1); add(4'h0,0,100,0,1,0);
        // To BIN, three Up presses, commit two cycles after vsync high
        add(4'h4,0,100,0,0,1); add(4'h4,0,100,0,0,1); add(4'h4,0,100,0,0,1);
        add(4'h1,0,100,0,0,1); add(4'h1,0,100,0,0,1); add(4'h1,0,100,0,0,1);
        add(4'h0,1,100,0,0,1); add(4'h0,1,115,3,1,0); add(4'h0,0,115,3,0,0);
        // vsync rise with nothing pending
        add(4'h0,1,115,3,0,0); add(4'h0,0,115,3,0,0);
        // Back to RAW, where Up+Down is ignored
        add(4'h4,0,115,3,0,1); add(4'h0,1,115,3,0,1); add(4'h0,0,115,0,1,0);
        add(4'h3,0,115,0,0,0); add(4'h0,1,115,0,0,0); add(4'h0,0,115,0,0,0);
        // SOBEL, threshold to 130, then restore+mode+up together: restore wins
        add(4'h4,0,115,0,0,1); add(4'h4,0,115,0,0,1);
        add(4'h1,0,115,0,0,1); add(4'h1,0,115,0,0,1); add(4'h1,0,115,0,0,1);
        add(4'hD,0,115,0,0,1); add(4'h0,1,115,0,0,1); add(4'h0,0,100,2,1,0);
        // Restore at default is not accepted
        add(4'h8,0,100,2,0,0);

        rst_n       = 1'b0;
        bus.key_vld = 4'h0;
        bus.vsync   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_vsync_high", 8'd100, 2'd0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].key, vecs[i].vs);
            chk($sformatf("vec%0d", i), vecs[i].thr, vecs[i].mode, vecs[i].upd, vecs[i].pend);
        end

        // Up saturation in SOBEL: 100 -> 245, then 250, then stuck
        for (int i = 0; i < 29; i++) step(4'h1, 1'b0);
        step(4'h0, 1'b1); step(4'h0, 1'b0);
        chk("sat_up_245", 8'd245, 2'd2, 1'b1, 1'b0);
        step(4'h1, 1'b0);
        chk("sat_up_to_max_pend", 8'd245, 2'd2, 1'b0, 1'b1);
        step(4'h1, 1'b0);
        step(4'h0, 1'b1); step(4'h0, 1'b0);
        chk("sat_up_250", 8'd250, 2'd2, 1'b1, 1'b0);
        step(4'h1, 1'b0);
        chk("sat_up_at_max_ignored", 8'd250, 2'd2, 1'b0, 1'b0);

        // Down saturation: restore, 100 -> 15, then 10, then stuck
        step(4'h8, 1'b0);
        for (int i = 0; i < 17; i++) step(4'h2, 1'b0);
        step(4'h0, 1'b1); step(4'h0, 1'b0);
        chk("sat_dn_15", 8'd15, 2'd2, 1'b1, 1'b0);
        step(4'h2, 1'b0);
        chk("sat_dn_to_min_pend", 8'd15, 2'd2, 1'b0, 1'b1);
        step(4'h2, 1'b0);
        step(4'h0, 1'b1); step(4'h0, 1'b0);
        chk("sat_dn_10", 8'd10, 2'd2, 1'b1, 1'b0);
        step(4'h2, 1'b0);
        chk("sat_dn_at_min_ignored", 8'd10, 2'd2, 1'b0, 1'b0);

        // Mode key in the commit cycle: old shadow goes out, pend stays set
        step(4'h1, 1'b0);
        step(4'h0, 1'b1);
        step(4'h4, 1'b0);
        chk("commit_with_mode_key", 8'd15, 2'd2, 1'b1, 1'b1);
        step(4'h0, 1'b1); step(4'h0, 1'b0);
        chk("next_commit_mode", 8'd15, 2'd3, 1'b1, 1'b0);

        // Reset mid-operation drops pending edits; vsync high after it is no edge
        step(4'h4, 1'b1);
        chk("pend_before_reset", 8'd15, 2'd3, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 8'd100, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'h0, 1'b1); step(4'h0, 1'b1);
        chk("no_edge_after_reset", 8'd100, 2'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
